// File: rtl/regfile_wb_demux_pkg.sv
// Shared constants and types for the integer register file.
// Widths, register count and the hard-wired zero register index.
package regfile_wb_demux_pkg;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  typedef logic [XLEN-1:0]  xlen_t;
  typedef logic [AW-1:0]    reg_addr_t;
  typedef logic [NREGS-1:0] reg_vec_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_wb_demux_if.sv
// Write-back, issue and read-port bundle for the register file.
// master: issue/wb side drives; slave: register file.
interface regfile_wb_demux_if;
  import regfile_wb_demux_pkg::*;

  logic      wb_en;
  reg_addr_t wb_addr;
  xlen_t     wb_data;
  logic      iss_en;
  reg_addr_t iss_rd;
  reg_addr_t rs1_addr;
  reg_addr_t rs2_addr;
  xlen_t     rs1_data;
  xlen_t     rs2_data;
  logic      rs1_busy;
  logic      rs2_busy;

  modport master (
    output wb_en, wb_addr, wb_data,
    output iss_en, iss_rd,
    output rs1_addr, rs2_addr,
    input  rs1_data, rs2_data,
    input  rs1_busy, rs2_busy
  );

  modport slave (
    input  wb_en, wb_addr, wb_data,
    input  iss_en, iss_rd,
    input  rs1_addr, rs2_addr,
    output rs1_data, rs2_data,
    output rs1_busy, rs2_busy
  );

endinterface

// File: rtl/regfile_wb_demux_demux_1toN.sv
// Address to one-hot decoder, gated by en.
// Ports: en, sel[AW-1:0] in; onehot[NREGS-1:0] out.
module demux_1toN
  import regfile_wb_demux_pkg::*;
(
  input  logic      en,
  input  reg_addr_t sel,
  output reg_vec_t  onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/regfile_wb_demux.sv
// RV64 integer register file: demuxed write-back, two bypassed read
// ports and a per-register busy scoreboard. Ports: clk, rst_n, bus.
module regfile_wb_demux
  import regfile_wb_demux_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_demux_if.slave    bus
);

  xlen_t    regs [NREGS];
  reg_vec_t busy;
  reg_vec_t wb_oh;
  reg_vec_t iss_oh;
  reg_vec_t busy_nxt;

  demux_1toN u_wb_dmx (
    .en     (bus.wb_en),
    .sel    (bus.wb_addr),
    .onehot (wb_oh)
  );

  demux_1toN u_iss_dmx (
    .en     (bus.iss_en),
    .sel    (bus.iss_rd),
    .onehot (iss_oh)
  );

  // x0 is hard-wired: loop starts at 1 so it only ever sees reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++)
        if (wb_oh[i]) regs[i] <= bus.wb_data;
    end
  end

  // Set is applied after clear so a same-register issue wins.
  always_comb begin
    busy_nxt    = (busy & ~wb_oh) | iss_oh;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  function automatic xlen_t rd_data(
    input reg_addr_t a
  );
    if (a == REG_ZERO)
      return '0;
    if (bus.wb_en && bus.wb_addr == a)
      return bus.wb_data;
    return regs[a];
  endfunction

  function automatic logic rd_busy(
    input reg_addr_t a
  );
    if (a == REG_ZERO)
      return 1'b0;
    if (bus.wb_en && bus.wb_addr == a)
      return 1'b0;
    return busy[a];
  endfunction

  always_comb begin
    bus.rs1_data = rd_data(bus.rs1_addr);
    bus.rs2_data = rd_data(bus.rs2_addr);
    bus.rs1_busy = rd_busy(bus.rs1_addr);
    bus.rs2_busy = rd_busy(bus.rs2_addr);
  end

endmodule

// File: tb/tb_regfile_wb_demux.sv
// Self-checking bench for regfile_wb_demux.
// Scoreboard of expected read-port values against a reference model.
module tb_regfile_wb_demux;
  import regfile_wb_demux_pkg::*;

  logic clk;
  logic rst_n;

  regfile_wb_demux_if bus ();

  regfile_wb_demux dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    step;
    xlen_t d1;
    xlen_t d2;
    logic  b1;
    logic  b2;
  } exp_t;

  exp_t  sb [$];
  xlen_t m_reg [NREGS];
  logic [NREGS-1:0] m_busy;
  int    n_cmp;
  int    n_err;
  int    step_no;
  string cur_tag;

  task automatic chk(
    input string nm,
    input xlen_t obs,
    input xlen_t exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s.%s step %0d: got %h want %h",
             cur_tag, nm, step_no, obs, exp);
    end
  endtask

  function automatic xlen_t m_rd(
    input reg_addr_t a,
    input logic we,
    input reg_addr_t wa,
    input xlen_t wd
  );
    if (a == 0) return '0;
    if (we && wa == a) return wd;
    return m_reg[a];
  endfunction

  function automatic logic m_bz(
    input reg_addr_t a,
    input logic we,
    input reg_addr_t wa
  );
    if (a == 0) return 1'b0;
    if (we && wa == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic step(
    input string     tag,
    input logic      rst,
    input logic      we,
    input reg_addr_t wa,
    input xlen_t     wd,
    input logic      ie,
    input reg_addr_t ir,
    input reg_addr_t a1,
    input reg_addr_t a2
  );
    exp_t e;
    @(negedge clk);
    cur_tag      = tag;
    step_no++;
    rst_n        = ~rst;
    bus.wb_en    = we;
    bus.wb_addr  = wa;
    bus.wb_data  = wd;
    bus.iss_en   = ie;
    bus.iss_rd   = ir;
    bus.rs1_addr = a1;
    bus.rs2_addr = a2;
    e.step = step_no;
    e.d1   = m_rd(a1, we, wa, wd);
    e.d2   = m_rd(a2, we, wa, wd);
    e.b1   = m_bz(a1, we, wa);
    e.b2   = m_bz(a2, we, wa);
    sb.push_back(e);
    #2;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s.queue: got empty want entry", tag);
    end else begin
      e = sb.pop_front();
      chk("rs1_data", bus.rs1_data, e.d1);
      chk("rs2_data", bus.rs2_data, e.d2);
      chk("rs1_busy", {63'd0, bus.rs1_busy}, {63'd0, e.b1});
      chk("rs2_busy", {63'd0, bus.rs2_busy}, {63'd0, e.b2});
    end
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < NREGS; i++) m_reg[i] = '0;
      m_busy = '0;
    end else begin
      if (we && wa != 0) m_reg[wa] = wd;
      if (we) m_busy[wa] = 1'b0;
      if (ie && ir != 0) m_busy[ir] = 1'b1;
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    step_no = 0;
    for (int i = 0; i < NREGS; i++) m_reg[i] = '0;
    m_busy       = '0;
    rst_n        = 1'b0;
    bus.wb_en    = 1'b0;
    bus.wb_addr  = '0;
    bus.wb_data  = '0;
    bus.iss_en   = 1'b0;
    bus.iss_rd   = '0;
    bus.rs1_addr = '0;
    bus.rs2_addr = '0;

    step("rst0", 1, 0, 0, 0, 0, 0, 1, 31);
    step("rst0", 0, 0, 0, 0, 0, 0, 1, 31);

    // x5 written, then busy x5, then reset for two cycles
    step("rst_wr", 0, 1, 5, 64'hDEAD, 1, 11, 5, 11);
    step("rst_pre", 0, 0, 0, 0, 1, 5, 5, 11);
    step("rst_a", 1, 0, 0, 0, 0, 0, 5, 11);
    step("rst_b", 1, 0, 0, 0, 0, 0, 5, 11);
    step("rst_chk", 0, 0, 0, 0, 0, 0, 5, 11);
    // reset with simultaneous wb to x6
    step("rst_wb", 1, 1, 6, 64'hBEEF, 1, 6, 6, 5);
    step("rst_wb_chk", 0, 0, 0, 0, 0, 0, 6, 6);

    // write and dual read of same register
    step("wr7", 0, 1, 7, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0);
    step("rd7", 0, 0, 0, 0, 0, 0, 7, 7);
    for (int i = 1; i < NREGS; i++)
      step("onehot", 0, 0, 0, 0, 0, 0, reg_addr_t'(i), 8);

    // x0 writes and issues are dropped
    step("x0_wr", 0, 1, 0, '1, 1, 0, 0, 0);
    step("x0_rd", 0, 0, 0, 0, 0, 0, 0, 0);

    // bypass: x9 holds 0x11, then same-cycle write 0x55
    step("byp_pre", 0, 1, 9, 64'h11, 1, 9, 9, 9);
    step("byp_busy", 0, 0, 0, 0, 0, 0, 9, 9);
    step("byp", 0, 1, 9, 64'h55, 0, 0, 7, 9);
    step("byp_hold", 0, 0, 0, 0, 0, 0, 9, 9);

    // scoreboard: set, set+clear same reg, clear
    step("iss10", 0, 0, 0, 0, 1, 10, 10, 10);
    step("busy10", 0, 0, 0, 0, 0, 0, 10, 3);
    step("iss_wb10", 0, 1, 10, 64'hA0, 1, 10, 10, 3);
    step("still10", 0, 0, 0, 0, 0, 0, 10, 10);
    step("wb10", 0, 1, 10, 64'hA1, 0, 0, 3, 10);
    step("free10", 0, 0, 0, 0, 0, 0, 10, 10);
    // different registers in one cycle
    step("diff", 0, 1, 9, 64'h66, 1, 12, 12, 9);
    step("diff_chk", 0, 0, 0, 0, 0, 0, 12, 9);

    for (int k = 0; k < 2000; k++) begin
      step("rand", 0,
           1'($urandom_range(0, 1)),
           reg_addr_t'($urandom_range(0, 31)),
           {$urandom, $urandom},
           1'($urandom_range(0, 1)),
           reg_addr_t'($urandom_range(0, 31)),
           reg_addr_t'($urandom_range(0, 31)),
           reg_addr_t'($urandom_range(0, 31)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
